// File: rtl/column_select_pkg.sv
// Shared definitions for the column-select chain transmitter and receiver.
// Provides the chain-length and index-width helpers and the sequence FSM state type.
package column_select_pkg;

    // Total chain length: one bit per column plus trailing non-column bits.
    function automatic int unsigned chain_len(input int unsigned cols,
                                              input int unsigned extra_bits);
        return cols + extra_bits;
    endfunction

    // Width of a column index; never narrower than one bit.
    function automatic int unsigned index_width(input int unsigned n);
        return (n > 32'd1) ? $unsigned($clog2(n)) : 32'd1;
    endfunction

    // Column stepping checker: no one-hot reference yet, or tracking the last index.
    typedef enum logic {
        SEQ_NO_REF = 1'b0,
        SEQ_TRACK  = 1'b1
    } seq_state_t;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge detector.
// Ports:
//   clk, rst_n : system clock, async active-low reset
//   din        : asynchronous input strobe
//   rise       : one-cycle pulse, registered, two cycles after din is first sampled high
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Synchronize, remember the previous level, register the rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            rise   <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise   <= sync_q & ~prev_q;
        end
    end

endmodule

// File: rtl/column_select_rx.sv
// Receiver model of the 74HC595-style column-select chain.
// Rebuilds shift and storage registers from the serial pins, decodes the latched
// column vector and checks that the selected column steps by one (or restarts at 0).
// Ports:
//   clk, rst_n   : system clock, async active-low reset
//   ser_clk      : shift clock pin (async)
//   ser_data     : serial data pin (async)
//   ser_stcp     : storage latch strobe pin (async)
//   ser_n_enable : active-low output enable pin (async)
//   columns      : storage column bits, zero while disabled
//   extra        : storage trailing bits, ungated
//   enabled      : synchronized inverse of ser_n_enable
//   col_valid    : one-cycle pulse per latch
//   col_index    : lowest set column in storage, 0 if none
//   one_hot      : exactly one column bit set in storage
//   shift_count  : shifts between previous and current latch, saturating
//   seq_error    : stepping violation, qualified by col_valid
module column_select_rx
    import column_select_pkg::*;
#(
    parameter  int unsigned COLUMN_NUMBER = 16,
    parameter  int unsigned EXTRA_BITS    = 1,
    parameter  int unsigned CNT_W         = 8,
    localparam int unsigned CHAIN         = chain_len(COLUMN_NUMBER, EXTRA_BITS),
    localparam int unsigned IDX_W         = index_width(COLUMN_NUMBER)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ser_clk,
    input  logic                     ser_data,
    input  logic                     ser_stcp,
    input  logic                     ser_n_enable,
    output logic [COLUMN_NUMBER-1:0] columns,
    output logic [EXTRA_BITS-1:0]    extra,
    output logic                     enabled,
    output logic                     col_valid,
    output logic [IDX_W-1:0]         col_index,
    output logic                     one_hot,
    output logic [CNT_W-1:0]         shift_count,
    output logic                     seq_error
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COLUMN_NUMBER - 1);

    logic                     shift_ev;
    logic                     latch_ev;
    logic                     data_meta_q;
    logic                     data_sync_q;
    logic                     data_q;
    logic                     en_meta_q;
    logic [CHAIN-1:0]         sr;
    logic [CHAIN-1:0]         st;
    logic [CNT_W-1:0]         cnt;
    logic [CNT_W-1:0]         cnt_inc_c;
    logic [COLUMN_NUMBER-1:0] sr_cols_c;
    logic                     one_hot_c;
    logic [IDX_W-1:0]         low_idx_c;
    logic                     found_c;
    logic [IDX_W-1:0]         exp_idx_c;
    logic                     seq_err_c;
    logic [IDX_W-1:0]         prev_index;
    seq_state_t               state_q;
    seq_state_t               state_d;

    sync_edge u_clk_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ser_clk),
        .rise  (shift_ev)
    );

    sync_edge u_stcp_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ser_stcp),
        .rise  (latch_ev)
    );

    // Data gets the same three-register depth as the shift-clock edge path.
    // Enable is synchronized inverted so its second stage is the output itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_meta_q <= 1'b0;
            data_sync_q <= 1'b0;
            data_q      <= 1'b0;
            en_meta_q   <= 1'b0;
            enabled     <= 1'b0;
        end else begin
            data_meta_q <= ser_data;
            data_sync_q <= data_meta_q;
            data_q      <= data_sync_q;
            en_meta_q   <= ~ser_n_enable;
            enabled     <= en_meta_q;
        end
    end

    assign cnt_inc_c = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    assign sr_cols_c = sr[COLUMN_NUMBER-1:0];

    // Decode the value about to be latched (pre-shift sr).
    always_comb begin
        low_idx_c = '0;
        found_c   = 1'b0;
        for (int unsigned i = 0; i < COLUMN_NUMBER; i++) begin
            if (sr_cols_c[i] && !found_c) begin
                low_idx_c = IDX_W'(i);
                found_c   = 1'b1;
            end
        end
        one_hot_c = (sr_cols_c != '0) &&
                    ((sr_cols_c & (sr_cols_c - COLUMN_NUMBER'(1))) == '0);
    end

    // Sequence FSM: state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= SEQ_NO_REF;
            prev_index <= '0;
        end else begin
            state_q <= state_d;
            if (latch_ev && one_hot_c) begin
                prev_index <= low_idx_c;
            end
        end
    end

    // Sequence FSM: next state. Any non-one-hot latch drops the reference.
    always_comb begin
        state_d = state_q;
        if (latch_ev) begin
            state_d = one_hot_c ? SEQ_TRACK : SEQ_NO_REF;
        end
    end

    // Sequence FSM: error output. Index 0 is always an accepted restart.
    always_comb begin
        seq_err_c = 1'b0;
        exp_idx_c = (prev_index == LAST_IDX) ? '0 : prev_index + IDX_W'(1);
        case (state_q)
            SEQ_TRACK: begin
                if (one_hot_c && (low_idx_c != exp_idx_c) && (low_idx_c != '0)) begin
                    seq_err_c = 1'b1;
                end
            end
            default: seq_err_c = 1'b0;
        endcase
    end

    // Shift, storage, counter and registered decode outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr          <= '0;
            st          <= '0;
            cnt         <= '0;
            col_valid   <= 1'b0;
            col_index   <= '0;
            one_hot     <= 1'b0;
            shift_count <= '0;
            seq_error   <= 1'b0;
        end else begin
            col_valid <= latch_ev;
            if (shift_ev) begin
                sr <= {sr[CHAIN-2:0], data_q};
            end
            if (latch_ev) begin
                st          <= sr;
                col_index   <= low_idx_c;
                one_hot     <= one_hot_c;
                seq_error   <= seq_err_c;
                // A coinciding shift is counted toward this latch.
                shift_count <= shift_ev ? cnt_inc_c : cnt;
                cnt         <= '0;
            end else if (shift_ev) begin
                cnt <= cnt_inc_c;
            end
        end
    end

    assign columns = st[COLUMN_NUMBER-1:0] & {COLUMN_NUMBER{enabled}};
    assign extra   = st[CHAIN-1:COLUMN_NUMBER];

endmodule

// File: tb/tb_column_select_rx.sv
// Self-checking bench for column_select_rx (3 columns, 1 extra bit).
// A pin-level reference model tracks the chain contents, shift count and
// column stepping rule; each scenario task compares DUT outputs against it.
module tb_column_select_rx;

    localparam int NC = 3;
    localparam int NE = 1;
    localparam int CH = NC + NE;
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          ser_clk;
    logic          ser_data;
    logic          ser_stcp;
    logic          ser_n_enable;
    logic [NC-1:0] columns;
    logic [NE-1:0] extra;
    logic          enabled;
    logic          col_valid;
    logic [1:0]    col_index;
    logic          one_hot;
    logic [CW-1:0] shift_count;
    logic          seq_error;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int m_sr, m_st, m_cnt, m_have_ref, m_prev, m_en;
    int exp_cols, exp_extra, exp_idx, exp_oh, exp_cnt, exp_err;

    // Observations captured at the col_valid pulse
    int            obs_lat;
    logic          obs_next;
    logic [NC-1:0] obs_cols;
    logic [NE-1:0] obs_extra;
    logic [1:0]    obs_idx;
    logic          obs_oh;
    logic [CW-1:0] obs_cnt;
    logic          obs_err;

    column_select_rx #(
        .COLUMN_NUMBER (NC),
        .EXTRA_BITS    (NE),
        .CNT_W         (CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ser_clk      (ser_clk),
        .ser_data     (ser_data),
        .ser_stcp     (ser_stcp),
        .ser_n_enable (ser_n_enable),
        .columns      (columns),
        .extra        (extra),
        .enabled      (enabled),
        .col_valid    (col_valid),
        .col_index    (col_index),
        .one_hot      (one_hot),
        .shift_count  (shift_count),
        .seq_error    (seq_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void model_reset();
        m_sr = 0; m_st = 0; m_cnt = 0; m_have_ref = 0; m_prev = 0;
    endfunction

    function automatic void model_shift(input int b);
        m_sr  = (m_sr * 2 + b) % (1 << CH);
        m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : CMAX;
    endfunction

    // Latch the chain; a coinciding shift is counted but stores the old chain.
    function automatic void model_latch(input int with_shift, input int b);
        int cols, ones, idx, oh;
        m_st = m_sr;
        if (with_shift != 0) model_shift(b);
        exp_cnt = m_cnt;
        m_cnt = 0;
        cols = m_st % (1 << NC);
        ones = 0;
        idx  = 0;
        for (int i = NC - 1; i >= 0; i--) begin
            if (((cols >> i) & 1) == 1) begin
                ones++;
                idx = i;
            end
        end
        oh = (ones == 1) ? 1 : 0;
        exp_err = (m_have_ref != 0 && oh != 0 && idx != (m_prev + 1) % NC && idx != 0) ? 1 : 0;
        if (oh != 0) m_prev = idx;
        m_have_ref = oh;
        exp_cols  = (m_en != 0) ? cols : 0;
        exp_extra = m_st >> NC;
        exp_idx   = idx;
        exp_oh    = oh;
    endfunction

    task automatic shift_bit(input int b);
        @(negedge clk);
        ser_data = b[0];
        repeat (2) @(negedge clk);
        ser_clk = 1'b1;
        repeat (4) @(negedge clk);
        ser_clk = 1'b0;
        repeat (3) @(negedge clk);
        model_shift(b);
    endtask

    // Raise stcp (optionally with ser_clk on the same cycle) and capture the pulse.
    task automatic pulse_latch(input int with_shift, input int b);
        @(negedge clk);
        if (with_shift != 0) begin
            ser_data = b[0];
            repeat (2) @(negedge clk);
        end
        ser_stcp = 1'b1;
        if (with_shift != 0) ser_clk = 1'b1;
        model_latch(with_shift, b);
        obs_lat = -1;
        for (int cyc = 0; cyc < 10 && obs_lat < 0; cyc++) begin
            @(posedge clk);
            #1;
            if (col_valid === 1'b1) begin
                obs_lat   = cyc;
                obs_cols  = columns;
                obs_extra = extra;
                obs_idx   = col_index;
                obs_oh    = one_hot;
                obs_cnt   = shift_count;
                obs_err   = seq_error;
            end
        end
        @(posedge clk);
        #1;
        obs_next = col_valid;
        @(negedge clk);
        ser_stcp = 1'b0;
        ser_clk  = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [17:0] o;
        rst_n = 1'b0;
        ser_n_enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ser_clk  = 1'($urandom_range(0, 1));
            ser_data = 1'($urandom_range(0, 1));
            ser_stcp = 1'($urandom_range(0, 1));
            ser_n_enable = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            o = {columns, extra, enabled, col_valid, col_index, one_hot, shift_count, seq_error};
            n_checks++;
            if (o !== 18'h0) begin
                n_errors++;
                $display("FAIL reset_outputs cycle %0d got %h want 0", i, o);
            end
        end
        @(negedge clk);
        ser_clk = 1'b0; ser_data = 1'b0; ser_stcp = 1'b0; ser_n_enable = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        m_en = 1;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if ({enabled, col_valid} !== 2'b10) begin
            n_errors++;
            $display("FAIL post_reset_enable got %b want 10", {enabled, col_valid});
        end
    endtask

    task automatic test_first_latch();
        shift_bit(1);
        pulse_latch(0, 0);
        n_checks++;
        if (obs_lat !== 3) begin
            n_errors++;
            $display("FAIL first_latency got %0d want 3", obs_lat);
        end
        n_checks++;
        if (obs_cols !== 3'b001 || obs_cols !== NC'(exp_cols)) begin
            n_errors++;
            $display("FAIL first_columns got %b want 001", obs_cols);
        end
        n_checks++;
        if ({obs_idx, obs_oh, obs_cnt, obs_err} !== {2'd0, 1'b1, 8'd1, 1'b0}) begin
            n_errors++;
            $display("FAIL first_decode got idx %0d oh %b cnt %0d err %b want 0 1 1 0",
                     obs_idx, obs_oh, obs_cnt, obs_err);
        end
        n_checks++;
        if (obs_next !== 1'b0) begin
            n_errors++;
            $display("FAIL first_pulse_width col_valid still %b want 0", obs_next);
        end
    endtask

    task automatic test_stepping();
        for (int k = 1; k <= 3; k++) begin
            shift_bit(0);
            pulse_latch(0, 0);
            n_checks++;
            if ({obs_cols, obs_extra, obs_idx, obs_oh, obs_err} !==
                {NC'(exp_cols), NE'(exp_extra), 2'(exp_idx), 1'(exp_oh), 1'(exp_err)}) begin
                n_errors++;
                $display("FAIL step_%0d got cols %b extra %b idx %0d oh %b err %b want %b %b %0d %0d %0d",
                         k, obs_cols, obs_extra, obs_idx, obs_oh, obs_err,
                         NC'(exp_cols), NE'(exp_extra), exp_idx, exp_oh, exp_err);
            end
        end
        // After losing the reference, a non-sequential one-hot must not flag an error.
        shift_bit(0); shift_bit(1); shift_bit(0);
        pulse_latch(0, 0);
        n_checks++;
        if ({obs_idx, obs_oh, obs_err} !== {2'(exp_idx), 1'(exp_oh), 1'(exp_err)} || obs_err !== 1'b0) begin
            n_errors++;
            $display("FAIL no_ref_resume got idx %0d oh %b err %b want %0d %0d 0",
                     obs_idx, obs_oh, obs_err, exp_idx, exp_oh);
        end
    endtask

    task automatic test_skip();
        shift_bit(0); shift_bit(0); shift_bit(0); shift_bit(1);
        pulse_latch(0, 0);
        shift_bit(0); shift_bit(0);
        pulse_latch(0, 0);
        n_checks++;
        if ({obs_idx, obs_err, obs_cnt} !== {2'd2, 1'b1, 8'd2} ||
            {obs_idx, obs_err, obs_cnt} !== {2'(exp_idx), 1'(exp_err), CW'(exp_cnt)}) begin
            n_errors++;
            $display("FAIL skip got idx %0d err %b cnt %0d want 2 1 2", obs_idx, obs_err, obs_cnt);
        end
    endtask

    task automatic test_simultaneous();
        shift_bit(0); shift_bit(0); shift_bit(0); shift_bit(1);
        pulse_latch(1, 0);
        n_checks++;
        if ({obs_cols, obs_extra, obs_cnt} !== {NC'(exp_cols), NE'(exp_extra), CW'(exp_cnt)} ||
            obs_cols !== 3'b001) begin
            n_errors++;
            $display("FAIL simul_latch got cols %b extra %b cnt %0d want %b %b %0d",
                     obs_cols, obs_extra, obs_cnt, NC'(exp_cols), NE'(exp_extra), exp_cnt);
        end
        pulse_latch(0, 0);
        n_checks++;
        if ({obs_idx, obs_cols, obs_cnt} !== {2'd1, 3'b010, 8'd0}) begin
            n_errors++;
            $display("FAIL simul_followup got idx %0d cols %b cnt %0d want 1 010 0",
                     obs_idx, obs_cols, obs_cnt);
        end
    endtask

    task automatic test_enable();
        @(negedge clk);
        ser_n_enable = 1'b1;
        m_en = 0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({enabled, columns} !== 4'b0000) begin
            n_errors++;
            $display("FAIL disable got en %b cols %b want 0 000", enabled, columns);
        end
        shift_bit(0);
        pulse_latch(0, 0);
        n_checks++;
        if ({obs_cols, obs_oh, obs_idx} !== {3'b000, 1'(exp_oh), 2'(exp_idx)}) begin
            n_errors++;
            $display("FAIL disabled_latch got cols %b oh %b idx %0d want 000 %0d %0d",
                     obs_cols, obs_oh, obs_idx, exp_oh, exp_idx);
        end
        @(negedge clk);
        ser_n_enable = 1'b0;
        m_en = 1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({enabled, columns} !== 4'b0000) begin
            n_errors++;
            $display("FAIL enable_early got en %b cols %b want 0 000", enabled, columns);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if ({enabled, columns} !== {1'b1, NC'(m_st % (1 << NC))}) begin
            n_errors++;
            $display("FAIL enable_restore got en %b cols %b want 1 %b",
                     enabled, columns, NC'(m_st % (1 << NC)));
        end
    endtask

    task automatic test_reset_mid();
        shift_bit(1); shift_bit(0);
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        repeat (4) @(negedge clk);
        pulse_latch(0, 0);
        n_checks++;
        if ({obs_cols, obs_extra, obs_oh, obs_cnt, obs_err} !== 14'h0 || obs_lat !== 3) begin
            n_errors++;
            $display("FAIL reset_mid got cols %b extra %b oh %b cnt %0d err %b lat %0d want all 0 lat 3",
                     obs_cols, obs_extra, obs_oh, obs_cnt, obs_err, obs_lat);
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < CMAX + 5; i++) shift_bit(int'($urandom_range(0, 1)));
        pulse_latch(0, 0);
        n_checks++;
        if (obs_cnt !== CW'(exp_cnt) || obs_cnt !== 8'd255) begin
            n_errors++;
            $display("FAIL saturation got %0d want 255", obs_cnt);
        end
    endtask

    task automatic test_random();
        logic [16:0] got, want;
        for (int it = 0; it < 40; it++) begin
            int nsh;
            nsh = int'($urandom_range(0, 3));
            for (int s = 0; s < nsh; s++) shift_bit(($urandom_range(0, 2) == 0) ? 1 : 0);
            pulse_latch(int'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0) ? 1 : 0);
            got  = {obs_cols, obs_extra, obs_idx, obs_oh, obs_cnt, obs_err, obs_next};
            want = {NC'(exp_cols), NE'(exp_extra), 2'(exp_idx), 1'(exp_oh), CW'(exp_cnt), 1'(exp_err), 1'b0};
            n_checks++;
            if (got !== want || obs_lat !== 3) begin
                n_errors++;
                $display("FAIL random_%0d got %h lat %0d want %h lat 3", it, got, obs_lat, want);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ser_clk = 1'b0; ser_data = 1'b0; ser_stcp = 1'b0; ser_n_enable = 1'b1;
        m_en = 0;
        model_reset();
        test_reset();
        test_first_latch();
        test_stepping();
        test_skip();
        test_simultaneous();
        test_enable();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/column_select_rx.md
# column_select_rx

Receiver-side model of the column-select shift-register chain (74HC595-style) driven by `column_select`. Samples the four serial pins (`ser_clk`, `ser_data`, `ser_stcp`, `ser_n_enable`) in the system clock domain and rebuilds the shift and storage registers. Decodes the latched column vector and checks the column stepping sequence. Used for FPGA loopback self-test of the matrix column path, and as the bench-side checker for `column_select`.

## Interface
- `COLUMN_NUMBER`, 16, number of matrix columns (one chain bit per column)
- `EXTRA_BITS`, 1, trailing non-column bits in the chain; CHAIN = COLUMN_NUMBER + EXTRA_BITS
- `CNT_W`, 8, width of the shift counter

Ports:
- `clk`  in  1  system clock; single clock domain
- `rst_n`  in  1  asynchronous, active-low reset
- `ser_clk`  in  1  shift clock from the transmitter; asynchronous to `clk`
- `ser_data`  in  1  serial data; asynchronous to `clk`
- `ser_stcp`  in  1  storage latch strobe; asynchronous to `clk`
- `ser_n_enable`  in  1  active-low output enable; asynchronous to `clk`
- `columns`  out  COLUMN_NUMBER  storage column bits, forced to 0 while disabled
- `extra`  out  EXTRA_BITS  storage extra bits, not gated by enable
- `enabled`  out  1  synchronized, inverted `ser_n_enable`
- `col_valid`  out  1  one-cycle pulse on every latch
- `col_index`  out  $clog2(COLUMN_NUMBER)  index of the lowest set column bit; 0 if none
- `one_hot`  out  1  exactly one column bit is set in storage
- `shift_count`  out  CNT_W  shifts between the previous latch and this one, saturating
- `seq_error`  out  1  sequence violation, valid while `col_valid` is high

## Operation
- Synchronizers: every input passes through two flip-flops. `ser_data` takes the same path as `ser_clk`, so the data and its clock edge stay aligned.
- Edge detect: one extra register per strobe. A rise on synchronized `ser_clk` produces `shift_ev`; a rise on synchronized `ser_stcp` produces `latch_ev`.
- Shift register `sr[CHAIN-1:0]`: on `shift_ev`, `sr <= {sr[CHAIN-2:0], data}`. The newest bit enters at `sr[0]`.
- Storage register `st`: on `latch_ev`, `st <= sr`. `columns = st[COLUMN_NUMBER-1:0] & {enabled}`; `extra = st[CHAIN-1:COLUMN_NUMBER]`.
- Simultaneous `shift_ev` and `latch_ev` in one cycle: `st` takes the pre-shift `sr`, and `sr` still shifts. This matches 74HC595 behaviour.
- Counter `cnt`: increments on `shift_ev` and saturates at 2^CNT_W-1. On `latch_ev`, `cnt` is copied to `shift_count` and cleared to 0. If a shift coincides with the latch, the copied value includes that shift and `cnt` restarts at 0.
- Decode: `one_hot`, `col_index` and `seq_error` are computed from the new storage value and registered together with `st`.
- Sequence FSM states:
  - NO_REF: no one-hot reference yet.
  - TRACK: holds `prev_index`.
- NO_REF transitions: a one-hot latch goes to TRACK; `seq_error` = 0.
- TRACK transitions:
  - One-hot latch: `seq_error` = 1 unless the index equals (`prev_index`+1) mod COLUMN_NUMBER or equals 0 (restart). Then update `prev_index`.
  - Non-one-hot latch: go to NO_REF; `seq_error` = 0.
- Reset mid-operation: all registers, synchronizers and the FSM clear immediately. A partial shift sequence is discarded.

## Timing
- Reset values: `columns`=0, `extra`=0, `enabled`=0, `col_valid`=0, `col_index`=0, `one_hot`=0, `shift_count`=0, `seq_error`=0. `sr`, `st` and `cnt` are 0; FSM is in NO_REF.
- A pin edge sampled at clk edge N becomes `shift_ev`/`latch_ev` at N+2. `sr` updates at N+3.
- A latch at N+3 updates `st`, `columns`, `extra`, `col_index`, `one_hot`, `shift_count` and `seq_error`, and pulses `col_valid` for exactly one cycle.
- `enabled` follows `ser_n_enable` with 2 cycles of latency. `columns` gating follows it combinationally from the synchronized value.
- Input constraint: `ser_clk` and `ser_stcp` must stay high and low for at least 3 `clk` periods each. `ser_data` must be stable from 1 period before to 3 periods after the rising edge of `ser_clk`. Violations are not detected.

## Structure
- Shared package `column_select_pkg`: the CHAIN length function, the index width helper, and the FSM state enum. The same helpers are used by `column_select`.
- Sub-module `sync_edge`: 2-FF synchronizer plus a registered rise detect. Instantiated for `ser_clk` and `ser_stcp`. `ser_data` and `ser_n_enable` use the synchronizer stages only.

## Test plan
All scenarios use COLUMN_NUMBER=3, EXTRA_BITS=1.
- Reset: hold `rst_n`=0 while toggling the pins. All outputs stay 0, and `col_valid` never pulses.
- Shift '1' then strobe `stcp` with `ser_n_enable`=0. Expect `columns`=3'b001, `col_index`=0, `one_hot`=1, `shift_count`=1, `seq_error`=0, and a `col_valid` pulse exactly 3 clk after the `stcp` rise.
- Shift '0' and latch, repeated. Expect `col_index` 1, then 2 with `seq_error`=0. On the next shift and latch expect `columns`=0, `extra`=1, `one_hot`=0, and the FSM returns to NO_REF.
- From `col_index` 0, shift two '0's, then latch. Expect `col_index`=2, `seq_error`=1, `shift_count`=2.
- Drive `ser_clk` and `stcp` rising on the same clk with `sr`=4'b0001. Expect `st`=0001 and `sr`=0010; the next latch alone gives `col_index`=1.
- With `ser_n_enable`=1, expect `columns`=0 while `st` is retained; dropping `ser_n_enable` restores the column bits 2 clk later. Assert `rst_n`=0 mid-shift: `sr`=0 and `shift_count`=0 at the next latch.
